// File: rtl/regfile_32x64_if.sv
// Register-file port bundle: one write port, two read ports.
// The master drives addresses and write data; the slave returns read data.
interface regfile_32x64_if #(
  parameter int WIDTH = 64
);
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );
endinterface

// File: rtl/regfile_32x64.sv
// 32 x WIDTH register file, one sync write port, two comb read ports.
// Entry ZERO_REG has no storage and always reads zero.
module regfile_32x64 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b0
) (
  input logic             clk,
  input logic             reset,
  regfile_32x64_if.slave  bus
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [31:0]      w_we;
  logic [WIDTH-1:0] w_q [32];
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic             w_byp1;
  logic             w_byp2;

  // 5:32 write decoder gated by RegWrite
  always_comb begin
    w_we = '0;
    if (bus.RegWrite && (bus.WriteRegister != ZR))
      w_we[bus.WriteRegister] = 1'b1;
  end

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign w_q[i] = '0;
    end else begin : g_ff
      logic [WIDTH-1:0] r_q;

      always_ff @(posedge clk) begin
        if (reset)
          r_q <= '0;
        else if (w_we[i])
          r_q <= bus.WriteData;
      end

      assign w_q[i] = r_q;
    end
  end

  // One mux32_1 per read bit and port
  for (genvar b = 0; b < WIDTH; b++) begin : g_mux32_1
    logic [31:0] w_w;

    for (genvar i = 0; i < 32; i++) begin : g_w
      assign w_w[i] = w_q[i][b];
    end

    assign w_rd1[b] = w_w[bus.ReadRegister1];
    assign w_rd2[b] = w_w[bus.ReadRegister2];
  end

  assign w_byp1 = BYPASS && bus.RegWrite && !reset
               && (bus.ReadRegister1 == bus.WriteRegister)
               && (bus.WriteRegister != ZR);

  assign w_byp2 = BYPASS && bus.RegWrite && !reset
               && (bus.ReadRegister2 == bus.WriteRegister)
               && (bus.WriteRegister != ZR);

  assign bus.ReadData1 = w_byp1 ? bus.WriteData : w_rd1;
  assign bus.ReadData2 = w_byp2 ? bus.WriteData : w_rd2;

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64: a BYPASS=0 and a BYPASS=1
// instance share stimulus; a negedge monitor checks queued expectations.
module tb_regfile_32x64;

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] b1;
    logic [63:0] b2;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t sb_q [$];

  regfile_32x64_if #(.WIDTH(64)) if0 ();
  regfile_32x64_if #(.WIDTH(64)) if1 ();

  regfile_32x64 #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  regfile_32x64 #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    logic [63:0] v;
    v = 64'h0101010101010101;
    return (i == 31) ? 64'h0 : v * 64'(i);
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compare current outputs against the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp({e.name, " b0.rd1"}, if0.ReadData1, e.e1);
      cmp({e.name, " b0.rd2"}, if0.ReadData2, e.e2);
      cmp({e.name, " b1.rd1"}, if1.ReadData1, e.b1);
      cmp({e.name, " b1.rd2"}, if1.ReadData2, e.b2);
    end
  end

  task automatic drive(input logic rw, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic rst);
    reset             = rst;
    if0.RegWrite      = rw;
    if0.WriteRegister = wr;
    if0.WriteData     = wd;
    if0.ReadRegister1 = r1;
    if0.ReadRegister2 = r2;
    if1.RegWrite      = rw;
    if1.WriteRegister = wr;
    if1.WriteData     = wd;
    if1.ReadRegister1 = r1;
    if1.ReadRegister2 = r2;
  endtask

  task automatic expect4(input string nm, input logic [63:0] e1,
                         input logic [63:0] e2, input logic [63:0] b1,
                         input logic [63:0] b2);
    exp_t e;
    e.name = nm;
    e.e1 = e1;
    e.e2 = e2;
    e.b1 = b1;
    e.b2 = b2;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b1);
    tick();
    tick();

    // Reset clears a loaded register
    drive(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd5, 5'd31, 1'b0);
    tick();
    drive(1'b0, 5'd5, 64'h0, 5'd5, 5'd31, 1'b0);
    expect4("x5_loaded", 64'hDEADBEEF_CAFEF00D, 64'h0,
            64'hDEADBEEF_CAFEF00D, 64'h0);
    tick();
    drive(1'b1, 5'd5, 64'h111, 5'd5, 5'd5, 1'b1);
    expect4("rst_pre_edge", 64'hDEADBEEF_CAFEF00D,
            64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D,
            64'hDEADBEEF_CAFEF00D);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 1'b0);
      expect4($sformatf("rst_sweep%0d", i), 64'h0, 64'h0, 64'h0, 64'h0);
      tick();
    end

    // Write X0..X30, observing bypass during each write
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), pat(i), 5'(i), 5'd31, 1'b0);
      expect4($sformatf("wr%0d", i), 64'h0, 64'h0, pat(i), 64'h0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 1'b0);
      expect4($sformatf("rd_sweep%0d", i), pat(i), pat(31 - i),
              pat(i), pat(31 - i));
      tick();
    end

    // Zero register ignores writes and bypass
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b0);
    expect4("x31_pre", 64'h0, 64'h0, 64'h0, 64'h0);
    tick();
    drive(1'b0, 5'd31, 64'h0, 5'd31, 5'd30, 1'b0);
    expect4("x31_post", 64'h0, pat(30), 64'h0, pat(30));
    tick();

    // Write enable low holds value
    drive(1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd7, 64'h5678, 5'd7, 5'd7, 1'b0);
      expect4($sformatf("we_low%0d", k), 64'h1234, 64'h1234,
              64'h1234, 64'h1234);
      tick();
    end
    drive(1'b0, 5'd0, 64'h0, 5'd7, 5'd6, 1'b0);
    expect4("we_low_after", 64'h1234, pat(6), 64'h1234, pat(6));
    tick();

    // Same-cycle read/write hazard
    drive(1'b1, 5'd3, 64'hAAAA, 5'd3, 5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd3, 64'hBBBB, 5'd3, 5'd3, 1'b0);
    expect4("hazard_pre", 64'hAAAA, 64'hAAAA, 64'hBBBB, 64'hBBBB);
    tick();
    drive(1'b0, 5'd3, 64'h0, 5'd3, 5'd3, 1'b0);
    expect4("hazard_post", 64'hBBBB, 64'hBBBB, 64'hBBBB, 64'hBBBB);
    tick();

    // Reset beats a simultaneous write
    drive(1'b1, 5'd9, 64'h77, 5'd9, 5'd3, 1'b1);
    expect4("rst_wr_pre", pat(9), 64'hBBBB, pat(9), 64'hBBBB);
    tick();
    drive(1'b0, 5'd9, 64'h0, 5'd9, 5'd3, 1'b0);
    expect4("rst_wr_post", 64'h0, 64'h0, 64'h0, 64'h0);
    tick();

    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- 32-entry x 64-bit register file: one synchronous write port, two combinational read ports.
- Feeds the datapath's operand buses.
- Each read-port bit is selected by one mux32_1 instance, giving 64 bit-slices per port. The register file supplies the 32-bit "w" vector of each slice.
- Register X31 is hardwired to zero.

Parameters:
- WIDTH, 64, data width of each register and of each read/write data bus.
- ZERO_REG, 31, index of the hardwired-zero register.
- BYPASS, 0, 1 = a read of the register being written in the same cycle returns WriteData; 0 = the read returns the old stored value.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- RegWrite  input  1  write enable.
- WriteRegister  input  5  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.

Behaviour:
- Storage: 31 writable WIDTH-bit registers (indices 0..30 when ZERO_REG=31), built from D flip-flops.
- Hardwired zero: entry ZERO_REG has no storage and always reads 0.
- Reset: synchronous and active-high. On a rising edge of clk with reset=1, every register becomes 0.
  - Reset has priority over a simultaneous write, so that write is dropped.
  - After reset both read ports output 0 for all indices.
- Write:
  - On a rising edge with reset=0 and RegWrite=1, register[WriteRegister] <= WriteData. The new value is visible on the read ports in the following cycle.
  - A 5:32 decoder gated by RegWrite produces the per-register enables.
  - Writes to ZERO_REG are silently ignored.
  - RegWrite=0: no register changes, whatever the other inputs are.
- Read:
  - Purely combinational, zero-cycle latency from ReadRegisterN to ReadDataN.
  - Bit b of ReadDataN = mux32_1 with w[i] = register[i][b] and sel = ReadRegisterN.
  - The two ports are independent; both may address the same register.
- Same-cycle read/write of the same index:
  - BYPASS=0: ReadData shows the pre-edge value until the edge, then the new value.
  - BYPASS=1: when RegWrite=1, reset=0, ReadRegisterN==WriteRegister and WriteRegister!=ZERO_REG, ReadDataN = WriteData combinationally, before the edge.
  - The bypass never applies to ZERO_REG or while reset=1.
- Reset mid-operation: a register loaded in any earlier cycle is cleared on the reset edge. Reads during the reset cycle show the pre-edge contents (BYPASS suppressed) and show 0 after the edge.
- No X propagation: every read of an in-range index returns a defined value once the first reset edge has occurred.

Test Plan:
- Reset clears: write 0xDEADBEEF_CAFEF00D to X5; assert reset for 1 cycle -> ReadData1 with ReadRegister1=5 reads 0x0; all 32 indices read 0.
- Write/read all: write i*0x0101010101010101 to X0..X30 over 31 cycles, then sweep ReadRegister1 0..31 and ReadRegister2 31..0 -> each port returns the written pattern; index 31 returns 0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=0xFFFF_FFFF_FFFF_FFFF -> ReadData1 with ReadRegister1=31 reads 0 both before and after the edge.
- Write enable low: preload X7=0x1234; RegWrite=0, WriteRegister=7, WriteData=0x5678 for 3 edges -> X7 still reads 0x1234.
- Same-cycle hazard: X3=0xAAAA; write 0xBBBB to X3 with ReadRegister1=3 -> before the edge BYPASS=0 reads 0xAAAA and BYPASS=1 reads 0xBBBB; after the edge both read 0xBBBB.
- Reset beats write: reset=1 and RegWrite=1 with WriteRegister=9, WriteData=0x77 on the same edge -> X9 reads 0 after the edge.
